// File: rtl/tetris_vga_pkg.sv
// Shared constants for the Tetris VGA drawing path: screen geometry,
// 3-bit colour codes, scanner state encoding and the shape-mask bit convention.
package tetris_vga_pkg;

  localparam int SCREEN_W          = 160;
  localparam int SCREEN_H          = 120;
  localparam int CELL_LOG2_DEFAULT = 2;

  localparam logic [2:0] COLOUR_BLACK   = 3'b000;
  localparam logic [2:0] COLOUR_BLUE    = 3'b001;
  localparam logic [2:0] COLOUR_GREEN   = 3'b010;
  localparam logic [2:0] COLOUR_CYAN    = 3'b011;
  localparam logic [2:0] COLOUR_RED     = 3'b100;
  localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOUR_WHITE   = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } plot_state_e;

  // Shape mask bit index: row 0 is the top row, col 0 the left column.
  function automatic logic [3:0] shape_bit_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Row-major pixel walker over the piece footprint: px inner, py outer.
// last flags the final pixel (both counters at their maximum).
module pixel_scan_counter #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] px,
  output logic [W-1:0] py,
  output logic         last
);

  logic [W-1:0] px_q, px_d;
  logic [W-1:0] py_q, py_d;

  // Next count: clear wins over enable; py steps when px wraps.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clr) begin
      px_d = '0;
      py_d = '0;
    end else if (en) begin
      px_d = px_q + 1'b1;
      if (px_q == '1) py_d = py_q + 1'b1;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = (px_q == '1) && (py_q == '1);

endmodule

// File: rtl/piece_plotter.sv
// Piece footprint plotter: on req, walks the 4x4-cell footprint one pixel per
// clock and drives registered x/y/colour/plot to the VGA adapter.
//
// state | meaning
// IDLE  | waiting for req; counter held at (0,0); plot low, position/colour held
// SCAN  | issuing one footprint pixel per clock; leaves after the last pixel
module piece_plotter
  import tetris_vga_pkg::*;
#(
  parameter int CELL_LOG2 = CELL_LOG2_DEFAULT
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req,
  input  logic        erase,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [15:0] shape,
  input  logic [2:0]  colour,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [2:0]  VGA_COLOR,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int CW = 2 + CELL_LOG2;
  localparam logic [8:0] SCREEN_W_X = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H_Y = 8'(SCREEN_H);

  plot_state_e state_q, state_d;

  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [15:0] shape_q, shape_d;
  logic [2:0]  col_q, col_d;

  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_c_q, vga_c_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic          cnt_clr, cnt_en, cnt_last;
  logic [CW-1:0] px, py;
  logic [1:0]    cell_col, cell_row;
  logic          inmask;
  logic [8:0]    sx;
  logic [7:0]    sy;

  pixel_scan_counter #(.W(CW)) u_scan (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .px     (px),
    .py     (py),
    .last   (cnt_last)
  );

  assign cell_col = px[CW-1:CELL_LOG2];
  assign cell_row = py[CW-1:CELL_LOG2];
  assign inmask   = shape_q[shape_bit_idx(cell_row, cell_col)];
  assign sx       = {1'b0, x0_q} + 9'(px);
  assign sy       = {1'b0, y0_q} + 8'(py);

  // Next-state, request latch and counter control.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    shape_d = shape_q;
    col_d   = col_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          state_d = ST_SCAN;
          x0_d    = x0;
          y0_d    = y0;
          shape_d = shape;
          col_d   = erase ? COLOUR_BLACK : colour;
        end
      end
      ST_SCAN: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel outputs; done fires on the first idle cycle after a scan.
  always_comb begin
    vga_x_d = vga_x_q;
    vga_y_d = vga_y_q;
    vga_c_d = vga_c_q;
    plot_d  = 1'b0;
    busy_d  = (state_q == ST_SCAN);
    done_d  = (state_q == ST_IDLE) && busy_q;
    if (state_q == ST_SCAN) begin
      vga_x_d = sx[7:0];
      vga_y_d = sy[6:0];
      vga_c_d = col_q;
      plot_d  = inmask && (sx < SCREEN_W_X) && (sy < SCREEN_H_Y);
    end
  end

  // State, latched request and output registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      shape_q <= '0;
      col_q   <= '0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      shape_q <= shape_d;
      col_q   <= col_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_c_q <= vga_c_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign VGA_X     = vga_x_q;
  assign VGA_Y     = vga_y_q;
  assign VGA_COLOR = vga_c_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piece_plotter.sv
// Bench for piece_plotter: a timeline model predicts every output cycle from
// the accept edge; directed scenarios add literal expectations on top.
module tb_piece_plotter;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        req = 1'b0;
  logic        erase = 1'b0;
  logic [7:0]  x0 = '0;
  logic [6:0]  y0 = '0;
  logic [15:0] shape = '0;
  logic [2:0]  colour = '0;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot, busy, done;

  piece_plotter dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .erase(erase),
    .x0(x0), .y0(y0), .shape(shape), .colour(colour),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;
  int e       = 0;

  // model state
  int m_active = 0, t_start = 0, mx0 = 0, my0 = 0, mcol = 0;
  logic [15:0] mshape = '0;
  int exp_x = 0, exp_y = 0, exp_c = 0, exp_plot = 0, exp_busy = 0, exp_done = 0;

  // observed statistics for directed checks
  int n_plot, n_colnz, xmin, xmax, ymin, ymax, first_plot_e, done_e;

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, e);
  endtask

  task automatic clear_stats();
    n_plot = 0; n_colnz = 0;
    xmin = 999; xmax = -1; ymin = 999; ymax = -1;
    first_plot_e = -1; done_e = -1;
  endtask

  // Model: outputs after edge e follow from how many edges have passed since accept.
  always @(posedge Clock) begin
    int k, px, py, sx, sy;
    e++;
    if (!Resetn) begin
      m_active = 0;
      exp_x = 0; exp_y = 0; exp_c = 0; exp_plot = 0; exp_busy = 0; exp_done = 0;
    end else begin
      exp_plot = 0; exp_busy = 0; exp_done = 0;
      if (m_active != 0) begin
        k = e - t_start - 1;
        if (k >= 0 && k < 256) begin
          px = k % 16; py = k / 16;
          sx = mx0 + px; sy = my0 + py;
          exp_x = sx % 256; exp_y = sy % 128; exp_c = mcol;
          exp_busy = 1;
          exp_plot = (mshape[(py / 4) * 4 + px / 4] && sx < 160 && sy < 120) ? 1 : 0;
        end else if (k == 256) begin
          exp_done = 1;
        end
      end
      if (req && (m_active == 0 || e >= t_start + 257)) begin
        m_active = 1; t_start = e;
        mx0 = int'(x0); my0 = int'(y0); mshape = shape;
        mcol = erase ? 0 : int'(colour);
      end
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge Clock) begin
    if (e > 0) begin
      check("plot", int'(plot), exp_plot);
      check("busy", int'(busy), exp_busy);
      check("done", int'(done), exp_done);
      check("vga_x", int'(VGA_X), exp_x);
      check("vga_y", int'(VGA_Y), exp_y);
      check("vga_color", int'(VGA_COLOR), exp_c);
      if (plot) begin
        n_plot++;
        if (VGA_COLOR != 3'b000) n_colnz++;
        if (int'(VGA_X) < xmin) xmin = int'(VGA_X);
        if (int'(VGA_X) > xmax) xmax = int'(VGA_X);
        if (int'(VGA_Y) < ymin) ymin = int'(VGA_Y);
        if (int'(VGA_Y) > ymax) ymax = int'(VGA_Y);
        if (first_plot_e < 0) first_plot_e = e;
      end
      if (done) done_e = e;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic start(input logic [7:0] ax, input logic [6:0] ay, input logic [15:0] ash,
                       input logic [2:0] acol, input logic aer, output int t);
    clear_stats();
    x0 = ax; y0 = ay; shape = ash; colour = acol; erase = aer; req = 1'b1;
    tick();
    t = e;
    req = 1'b0;
    x0 = 8'hFF; y0 = 7'h7F; shape = 16'h0; colour = 3'b111; erase = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (e < target && guard < 5000) begin
      tick();
      guard++;
    end
    if (e < target) check("timeout", e, target);
  endtask

  initial begin
    int t, t2;
    clear_stats();

    // reset and idle
    repeat (3) tick();
    Resetn = 1'b1;
    repeat (10) tick();
    check("idle_no_plot", n_plot, 0);

    // 2x2-cell square
    start(8'd10, 7'd20, 16'h0033, 3'b100, 1'b0, t);
    wait_until(t + 258);
    check("sq_nplot", n_plot, 64);
    check("sq_xmin", xmin, 10);
    check("sq_xmax", xmax, 17);
    check("sq_ymin", ymin, 20);
    check("sq_ymax", ymax, 27);
    check("sq_first", first_plot_e, t + 1);
    check("sq_done", done_e, t + 257);

    // erase over the same footprint
    start(8'd10, 7'd20, 16'h0033, 3'b111, 1'b1, t);
    wait_until(t + 258);
    check("er_nplot", n_plot, 64);
    check("er_colour_nonzero", n_colnz, 0);
    check("er_first", first_plot_e, t + 1);

    // clipping at the bottom-right corner
    start(8'd150, 7'd112, 16'hFFFF, 3'b010, 1'b0, t);
    wait_until(t + 258);
    check("clip_nplot", n_plot, 80);
    check("clip_xmin", xmin, 150);
    check("clip_xmax", xmax, 159);
    check("clip_ymin", ymin, 112);
    check("clip_ymax", ymax, 119);
    check("clip_done", done_e, t + 257);

    // req while busy ignored; req held through done starts a new scan
    start(8'd40, 7'd30, 16'h8421, 3'b001, 1'b0, t);
    wait_until(t + 49);
    x0 = 8'd100; req = 1'b1;
    tick();
    req = 1'b0;
    wait_until(t + 256);
    x0 = 8'd0; y0 = 7'd0; shape = 16'h0001; colour = 3'b011; erase = 1'b0; req = 1'b1;
    tick();
    t2 = e;
    req = 1'b0;
    tick();
    check("busy_nplot", n_plot, 64);
    check("busy_xmin", xmin, 40);
    check("busy_done", done_e, t + 257);
    check("b2b_accept", t2, t + 257);
    clear_stats();
    wait_until(t2 + 258);
    check("b2b_first", first_plot_e, t + 258);
    check("b2b_nplot", n_plot, 16);
    check("b2b_xmin", xmin, 0);
    check("b2b_ymin", ymin, 0);

    // reset mid-scan
    start(8'd20, 7'd10, 16'hFFFF, 3'b101, 1'b0, t);
    wait_until(t + 99);
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    repeat (300) tick();
    check("rst_no_done", done_e, -1);
    start(8'd0, 7'd0, 16'h0001, 3'b110, 1'b0, t);
    wait_until(t + 258);
    check("rst_first", first_plot_e, t + 1);
    check("rst_nplot", n_plot, 16);
    check("rst_xmin", xmin, 0);
    check("rst_ymin", ymin, 0);
    check("rst_done", done_e, t + 257);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
